// File: rtl/ysyx_23060229_lsu_pkg.sv
// Shared LSU definitions: op codes (EXU typ encoding), FSM state encoding and
// op-class helper functions.
// Imported by the LSU top and its alignment sub-module.
package ysyx_23060229_lsu_pkg;

  localparam int TYP_W = 6;

  // Op codes follow the EXU typ encoding; only the ones the LSU cares about
  // are named here, everything else is treated as a non-memory op.
  localparam logic [TYP_W-1:0] TYP_ADDI = 6'd1;
  localparam logic [TYP_W-1:0] TYP_LB   = 6'd10;
  localparam logic [TYP_W-1:0] TYP_LH   = 6'd11;
  localparam logic [TYP_W-1:0] TYP_LW   = 6'd12;
  localparam logic [TYP_W-1:0] TYP_LBU  = 6'd13;
  localparam logic [TYP_W-1:0] TYP_LHU  = 6'd14;
  localparam logic [TYP_W-1:0] TYP_SB   = 6'd15;
  localparam logic [TYP_W-1:0] TYP_SH   = 6'd16;
  localparam logic [TYP_W-1:0] TYP_SW   = 6'd17;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RSP  = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  function automatic logic is_load(input logic [TYP_W-1:0] typ);
    return (typ == TYP_LB) || (typ == TYP_LH) || (typ == TYP_LW) ||
           (typ == TYP_LBU) || (typ == TYP_LHU);
  endfunction

  function automatic logic is_store(input logic [TYP_W-1:0] typ);
    return (typ == TYP_SB) || (typ == TYP_SH) || (typ == TYP_SW);
  endfunction

  function automatic logic is_mem(input logic [TYP_W-1:0] typ);
    return is_load(typ) || is_store(typ);
  endfunction

endpackage

// File: rtl/ysyx_23060229_lsu_if.sv
// LSU handshake bundle: upstream op channel, memory req/rsp bus, result channel.
// slave  = the LSU side; master = the core/memory environment driving it.
// Ports: in_* (op offer), mem_req_* / mem_rsp_* (bus), out_* (result).
interface ysyx_23060229_lsu_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_typ;
  logic [31:0] in_src1;
  logic [31:0] in_imm;
  logic [31:0] in_wdata;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;

  modport slave (
    input  in_valid, in_typ, in_src1, in_imm, in_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, out_ready,
    output in_ready, mem_req_valid, mem_req_addr, mem_req_wen,
    output mem_req_wdata, mem_req_wmask, out_valid, out_rdata, out_err
  );

  modport master (
    output in_valid, in_typ, in_src1, in_imm, in_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, out_ready,
    input  in_ready, mem_req_valid, mem_req_addr, mem_req_wen,
    input  mem_req_wdata, mem_req_wmask, out_valid, out_rdata, out_err
  );
endinterface

// File: rtl/ysyx_23060229_lsu_align.sv
// Byte-lane alignment for the LSU (purely combinational).
// Ports: off/typ/wdata/rdata in -> wmask, wdata_sh (shifted up to lane),
//        rdata_sh (shifted down to bit 0, upper bits raw), misalign flag.
module ysyx_23060229_lsu_align
  import ysyx_23060229_lsu_pkg::*;
(
  input  logic [1:0]       off,
  input  logic [TYP_W-1:0] typ,
  input  logic [31:0]      wdata,
  input  logic [31:0]      rdata,
  output logic [3:0]       wmask,
  output logic [31:0]      wdata_sh,
  output logic [31:0]      rdata_sh,
  output logic             misalign
);

  assign wdata_sh = wdata << {off, 3'b000};
  assign rdata_sh = rdata >> {off, 3'b000};

  // Loads never drive byte enables; only halfword/word ops can misalign.
  always_comb begin
    wmask    = 4'b0000;
    misalign = 1'b0;
    case (typ)
      TYP_SB:          wmask = 4'b0001 << off;
      TYP_SH: begin
        wmask    = 4'b0011 << off;
        misalign = off[0];
      end
      TYP_SW: begin
        wmask    = 4'b1111;
        misalign = |off;
      end
      TYP_LH, TYP_LHU: misalign = off[0];
      TYP_LW:          misalign = |off;
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_23060229_lsu.sv
// Multi-cycle load/store unit: latches src1+imm on accept, runs one req/rsp
// bus transfer, returns the lane-shifted load word (non-mem ops pass through).
// Ports: clk, rst (sync, active-high), bus (slave modport of ysyx_23060229_lsu_if).
module ysyx_23060229_lsu
  import ysyx_23060229_lsu_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input logic                  clk,
  input logic                  rst,
  ysyx_23060229_lsu_if.slave   bus
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  lsu_state_e  state;
  logic [1:0]  off_q;
  logic [CW-1:0] cnt;

  logic        in_ready_q;
  logic        req_valid_q;
  logic [31:0] req_addr_q;
  logic        req_wen_q;
  logic [31:0] req_wdata_q;
  logic [3:0]  req_wmask_q;
  logic        out_valid_q;
  logic [31:0] out_rdata_q;
  logic        out_err_q;

  logic [31:0] addr_sum;
  logic [1:0]  align_off;
  logic [3:0]  al_wmask;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_misalign;

  assign addr_sum = bus.in_src1 + bus.in_imm;
  // Store-side alignment uses the fresh sum at accept; the load-side shift
  // happens later in RSP and must use the latched offset.
  assign align_off = (state == LSU_IDLE) ? addr_sum[1:0] : off_q;

  ysyx_23060229_lsu_align u_align (
    .off      (align_off),
    .typ      (bus.in_typ),
    .wdata    (bus.in_wdata),
    .rdata    (bus.mem_rsp_rdata),
    .wmask    (al_wmask),
    .wdata_sh (al_wdata),
    .rdata_sh (al_rdata),
    .misalign (al_misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LSU_IDLE;
      off_q       <= 2'b00;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      req_valid_q <= 1'b0;
      req_addr_q  <= 32'h0;
      req_wen_q   <= 1'b0;
      req_wdata_q <= 32'h0;
      req_wmask_q <= 4'h0;
      out_valid_q <= 1'b0;
      out_rdata_q <= 32'h0;
      out_err_q   <= 1'b0;
    end else begin
      unique case (state)
        LSU_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            in_ready_q  <= 1'b0;
            out_err_q   <= 1'b0;
            out_rdata_q <= 32'h0;
            off_q       <= addr_sum[1:0];
            if (!is_mem(bus.in_typ)) begin
              state       <= LSU_DONE;
              out_valid_q <= 1'b1;
            end else if (al_misalign) begin
              // Misaligned ops never touch the bus.
              state       <= LSU_DONE;
              out_valid_q <= 1'b1;
              out_err_q   <= 1'b1;
            end else begin
              state       <= LSU_REQ;
              cnt         <= '0;
              req_valid_q <= 1'b1;
              req_addr_q  <= {addr_sum[31:2], 2'b00};
              req_wen_q   <= is_store(bus.in_typ);
              req_wdata_q <= is_store(bus.in_typ) ? al_wdata : 32'h0;
              req_wmask_q <= al_wmask;
            end
          end
        end
        LSU_REQ: begin
          if (bus.mem_req_ready) begin
            req_valid_q <= 1'b0;
            cnt         <= '0;
            state       <= LSU_RSP;
          end else if (cnt == CNT_MAX) begin
            req_valid_q <= 1'b0;
            out_err_q   <= 1'b1;
            out_rdata_q <= 32'h0;
            out_valid_q <= 1'b1;
            state       <= LSU_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LSU_RSP: begin
          // rsp_valid is only looked at here, so an early response that
          // coincides with the request handshake is dropped.
          if (bus.mem_rsp_valid) begin
            out_rdata_q <= req_wen_q ? 32'h0 : al_rdata;
            out_valid_q <= 1'b1;
            state       <= LSU_DONE;
          end else if (cnt == CNT_MAX) begin
            out_err_q   <= 1'b1;
            out_rdata_q <= 32'h0;
            out_valid_q <= 1'b1;
            state       <= LSU_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LSU_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= LSU_IDLE;
          end
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.mem_req_wen   = req_wen_q;
  assign bus.mem_req_wdata = req_wdata_q;
  assign bus.mem_req_wmask = req_wmask_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_rdata     = out_rdata_q;
  assign bus.out_err       = out_err_q;

endmodule
